// File: rtl/alu_issue_stage.sv
// Issue register ahead of the ALU. Selects and forwards the operands, and holds up to two
// operations in a main/skid pair so that in_ready can be a registered signal.
module alu_issue_stage #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned ALUOP_W   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALUOP_W-1:0]   in_aluop,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [WORD_SIZE-1:0] in_rs1_data,
  input  logic [WORD_SIZE-1:0] in_rs2_data,
  input  logic [WORD_SIZE-1:0] in_imm,
  input  logic                 in_use_imm,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 fwd_ex_valid,
  input  logic [REG_W-1:0]     fwd_ex_rd,
  input  logic [WORD_SIZE-1:0] fwd_ex_data,
  input  logic                 fwd_wb_valid,
  input  logic [REG_W-1:0]     fwd_wb_rd,
  input  logic [WORD_SIZE-1:0] fwd_wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUOP_W-1:0]   out_aluop,
  output logic [WORD_SIZE-1:0] out_port_a,
  output logic [WORD_SIZE-1:0] out_port_b,
  output logic [REG_W-1:0]     out_rd
);

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;

  typedef struct packed {
    logic [ALUOP_W-1:0]   aluop;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [REG_W-1:0]     rd;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic                 use_imm;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t m_q, m_d, s_q, s_d, cap;
  logic   in_ready_q, in_ready_d;
  logic   in_xfer, out_xfer;

  // EX beats WB; x0 is never forwarded; no match keeps the current value.
  function automatic logic [WORD_SIZE-1:0] fwd_pick(input logic [REG_W-1:0]     rs,
                                                    input logic [WORD_SIZE-1:0] cur);
    logic [WORD_SIZE-1:0] res;
    res = cur;
    if (rs != '0) begin
      if (fwd_ex_valid && fwd_ex_rd == rs)      res = fwd_ex_data;
      else if (fwd_wb_valid && fwd_wb_rd == rs) res = fwd_wb_data;
    end
    return res;
  endfunction

  function automatic entry_t refresh(input entry_t e);
    entry_t r;
    r   = e;
    r.a = fwd_pick(e.rs1, e.a);
    if (!e.use_imm) r.b = fwd_pick(e.rs2, e.b);
    return r;
  endfunction

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    cap         = '0;
    cap.aluop   = in_aluop;
    cap.rd      = in_rd;
    cap.rs1     = in_rs1;
    cap.rs2     = in_rs2;
    cap.use_imm = in_use_imm;
    cap.a       = fwd_pick(in_rs1, in_rs1_data);
    cap.b       = in_use_imm ? in_imm : fwd_pick(in_rs2, in_rs2_data);
  end

  always_comb begin
    state_d = state_q;
    m_d     = refresh(m_q);
    s_d     = refresh(s_q);
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          m_d     = cap;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          m_d = cap;
        end else if (in_xfer) begin
          s_d     = cap;
          state_d = StTwo;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_xfer) begin
          m_d     = refresh(s_q);
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      m_q.aluop  <= ALU_ADD;
      s_q        <= '0;
      s_q.aluop  <= ALU_ADD;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != StEmpty);
  assign out_aluop  = m_q.aluop;
  assign out_port_a = m_q.a;
  assign out_port_b = m_q.b;
  assign out_rd     = m_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: constant vector table, directed corner sequences
// and a random run against a queue-based reference model.
module tb_alu_issue_stage;
  localparam int W  = 32;
  localparam int RW = 5;
  localparam int OW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready, in_use_imm, flush, out_valid, out_ready;
  logic [OW-1:0] in_aluop, out_aluop;
  logic [RW-1:0] in_rs1, in_rs2, in_rd, fwd_ex_rd, fwd_wb_rd, out_rd;
  logic [W-1:0]  in_rs1_data, in_rs2_data, in_imm, fwd_ex_data, fwd_wb_data;
  logic [W-1:0]  out_port_a, out_port_b;
  logic          fwd_ex_valid, fwd_wb_valid;

  always #5 CLK = ~CLK;

  alu_issue_stage #(.WORD_SIZE(W), .REG_W(RW), .ALUOP_W(OW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_port_a(out_port_a), .out_port_b(out_port_b), .out_rd(out_rd)
  );

  // Reference model: an in-order queue of at most two pending operations.
  typedef struct {
    logic [OW-1:0] aluop;
    logic [RW-1:0] rs1, rs2, rd;
    logic          use_imm;
    logic [W-1:0]  a, b;
  } op_t;

  op_t q[$];
  bit  rdy_m = 1'b1;
  int  n_cmp = 0;
  int  n_bad = 0;

  typedef struct {
    logic [RW-1:0] rs1, rs2;
    logic [W-1:0]  d1, d2, imm;
    logic          use_imm;
    logic          ex_v;
    logic [RW-1:0] ex_rd;
    logic [W-1:0]  ex_d;
    logic          wb_v;
    logic [RW-1:0] wb_rd;
    logic [W-1:0]  wb_d;
    logic [W-1:0]  exp_a, exp_b;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [RW-1:0] rs, input logic [W-1:0] dflt);
    if (rs == 0) return dflt;
    if (fwd_ex_valid && fwd_ex_rd == rs) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == rs) return fwd_wb_data;
    return dflt;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    bit  ox, ix;
    op_t n;
    ox = (q.size() > 0) && out_ready;
    ix = in_valid && rdy_m;
    @(posedge CLK);
    if (RST) begin
      q.delete();
      rdy_m = 1'b1;
    end else begin
      if (ox) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        q[i].a = pick(q[i].rs1, q[i].a);
        if (!q[i].use_imm) q[i].b = pick(q[i].rs2, q[i].b);
      end
      if (ix) begin
        n.aluop   = in_aluop;
        n.rs1     = in_rs1;
        n.rs2     = in_rs2;
        n.rd      = in_rd;
        n.use_imm = in_use_imm;
        n.a       = pick(in_rs1, in_rs1_data);
        n.b       = in_use_imm ? in_imm : pick(in_rs2, in_rs2_data);
        q.push_back(n);
      end
      if (flush) q.delete();
      rdy_m = (q.size() < 2);
    end
    #1;
    check("model_out_valid", out_valid, q.size() > 0);
    check("model_in_ready", in_ready, rdy_m);
    if (q.size() > 0) begin
      check("model_aluop", out_aluop, q[0].aluop);
      check("model_port_a", out_port_a, q[0].a);
      check("model_port_b", out_port_b, q[0].b);
      check("model_rd", out_rd, q[0].rd);
    end
  endtask

  task automatic quiet();
    in_valid     = 1'b0;
    flush        = 1'b0;
    fwd_ex_valid = 1'b0;
    fwd_wb_valid = 1'b0;
  endtask

  task automatic set_op(input logic [OW-1:0] op, input logic [RW-1:0] r1,
                        input logic [W-1:0] d1, input logic [RW-1:0] r2,
                        input logic [W-1:0] d2, input logic [W-1:0] imm,
                        input logic ui, input logic [RW-1:0] rd);
    in_valid    = 1'b1;
    in_aluop    = op;
    in_rs1      = r1;
    in_rs1_data = d1;
    in_rs2      = r2;
    in_rs2_data = d2;
    in_imm      = imm;
    in_use_imm  = ui;
    in_rd       = rd;
  endtask

  task automatic do_reset();
    quiet();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b0; out_ready = 1'b1;
    in_aluop = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rs1_data = '0;
    in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0;
    fwd_ex_rd = '0; fwd_ex_data = '0; fwd_wb_rd = '0; fwd_wb_data = '0;
    quiet();
    //          rs1 rs2 d1      d2      imm  ui  exv exrd exd     wbv wbrd wbd     exp_a   exp_b
    vecs[0] = '{5'd1, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20,
                32'h10, 32'h7};
    vecs[1] = '{5'd0, 5'd2, 32'h0, 32'h7, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h7};
    vecs[2] = '{5'd1, 5'd1, 32'h5, 32'h9, 32'h0, 1'b0, 1'b0, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20,
                32'h20, 32'h20};
    vecs[3] = '{5'd3, 5'd1, 32'h33, 32'h9, 32'h8, 1'b1, 1'b1, 5'd1, 32'h10, 1'b0, 5'd0, 32'h0,
                32'h33, 32'h8};
    vecs[4] = '{5'd2, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 5'd2, 32'hE, 1'b1, 5'd2, 32'hB,
                32'hE, 32'hE};
    vecs[5] = '{5'd0, 5'd0, 32'h77, 32'h66, 32'h0, 1'b0, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2,
                32'h77, 32'h66};

    // Reset values.
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_aluop", out_aluop, 4'h0);
    check("rst_port_a", out_port_a, 32'h0);

    // Basic pass-through with one-cycle latency.
    set_op(4'h0, 5'd1, 32'h5, 5'd2, 32'h7, 32'h0, 1'b0, 5'd3);
    step();
    quiet();
    check("t1_valid", out_valid, 1'b1);
    check("t1_port_a", out_port_a, 32'h5);
    check("t1_port_b", out_port_b, 32'h7);
    check("t1_rd", out_rd, 5'd3);
    step();
    check("t1_drained", out_valid, 1'b0);

    // Operand selection table.
    foreach (vecs[i]) begin
      set_op(4'h2, vecs[i].rs1, vecs[i].d1, vecs[i].rs2, vecs[i].d2, vecs[i].imm,
             vecs[i].use_imm, 5'd7);
      fwd_ex_valid = vecs[i].ex_v; fwd_ex_rd = vecs[i].ex_rd; fwd_ex_data = vecs[i].ex_d;
      fwd_wb_valid = vecs[i].wb_v; fwd_wb_rd = vecs[i].wb_rd; fwd_wb_data = vecs[i].wb_d;
      step();
      quiet();
      check($sformatf("vec%0d_a", i), out_port_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), out_port_b, vecs[i].exp_b);
      step();
    end

    // Skid buffer: third push is refused, order preserved.
    out_ready = 1'b0;
    set_op(4'h1, 5'd1, 32'hA, 5'd2, 32'hA, 32'h0, 1'b0, 5'd10);
    step();
    set_op(4'h1, 5'd1, 32'hB, 5'd2, 32'hB, 32'h0, 1'b0, 5'd11);
    step();
    check("t3_in_ready_low", in_ready, 1'b0);
    set_op(4'h1, 5'd1, 32'hC, 5'd2, 32'hC, 32'h0, 1'b0, 5'd12);
    step();
    check("t3_hold_a", out_rd, 5'd10);
    quiet();
    out_ready = 1'b1;
    step();
    check("t3_second_b", out_rd, 5'd11);
    check("t3_in_ready_back", in_ready, 1'b1);
    step();
    check("t3_empty", out_valid, 1'b0);

    // Refresh of a held operand, and no refresh of an immediate.
    out_ready = 1'b0;
    set_op(4'h3, 5'd0, 32'h0, 5'd4, 32'h1, 32'h0, 1'b0, 5'd5);
    step();
    quiet();
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hABCD;
    step();
    quiet();
    check("t4_refresh_b", out_port_b, 32'hABCD);
    step();
    check("t4_refresh_kept", out_port_b, 32'hABCD);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    set_op(4'h3, 5'd0, 32'h0, 5'd4, 32'h1, 32'h8, 1'b1, 5'd5);
    step();
    quiet();
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hABCD;
    step();
    quiet();
    check("t4_imm_kept", out_port_b, 32'h8);
    out_ready = 1'b1;
    step();

    // Flush in TWO with a concurrent input.
    out_ready = 1'b0;
    set_op(4'h4, 5'd1, 32'h1, 5'd1, 32'h1, 32'h0, 1'b0, 5'd20);
    step();
    set_op(4'h4, 5'd1, 32'h2, 5'd1, 32'h2, 32'h0, 1'b0, 5'd21);
    step();
    set_op(4'h4, 5'd1, 32'h3, 5'd1, 32'h3, 32'h0, 1'b0, 5'd22);
    flush = 1'b1;
    step();
    quiet();
    check("t5_valid", out_valid, 1'b0);
    check("t5_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset in TWO.
    out_ready = 1'b0;
    set_op(4'h5, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 1'b0, 5'd9);
    step();
    step();
    do_reset();
    check("t6_valid", out_valid, 1'b0);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_port_a", out_port_a, 32'h0);
    check("t6_port_b", out_port_b, 32'h0);
    check("t6_rd", out_rd, 5'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      out_ready    = $urandom_range(0, 2) != 0;
      in_valid     = $urandom_range(0, 1);
      in_aluop     = OW'($urandom);
      in_rs1       = RW'($urandom_range(0, 3));
      in_rs2       = RW'($urandom_range(0, 3));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      in_use_imm   = $urandom_range(0, 1);
      in_rd        = RW'($urandom);
      fwd_ex_valid = $urandom_range(0, 1);
      fwd_ex_rd    = RW'($urandom_range(0, 3));
      fwd_ex_data  = $urandom;
      fwd_wb_valid = $urandom_range(0, 1);
      fwd_wb_rd    = RW'($urandom_range(0, 3));
      fwd_wb_data  = $urandom;
      step();
    end
    RST = 1'b0;
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute issue register that sits directly upstream of the ALU and drives its aluop, port_a and port_b inputs.
- Selects operands from the register file, an immediate, or forwarding paths from the EX and WB stages.
- Buffers up to two operations in a skid buffer, so a registered in_ready still loses no operation when the consumer stalls.
- Refreshes the operands of held operations from the forwarding ports while they wait.

Parameters:
- WORD_SIZE, 32, datapath width.
- REG_W, 5, register address width.
- ALUOP_W, 4, width of alu_types_pkg::aluop_t.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active high
- in_valid  in  1  decode presents an operation
- in_ready  out  1  stage can accept an operation; registered
- in_aluop  in  ALUOP_W  operation code
- in_rs1, in_rs2  in  REG_W  source register addresses
- in_rs1_data, in_rs2_data  in  WORD_SIZE  register file read data
- in_imm  in  WORD_SIZE  sign-extended immediate
- in_use_imm  in  1  operand b comes from in_imm
- in_rd  in  REG_W  destination register
- fwd_ex_valid  in  1  EX forwarding port valid
- fwd_ex_rd  in  REG_W  EX forwarding destination
- fwd_ex_data  in  WORD_SIZE  EX forwarding data
- fwd_wb_valid  in  1  WB forwarding port valid
- fwd_wb_rd  in  REG_W  WB forwarding destination
- fwd_wb_data  in  WORD_SIZE  WB forwarding data
- flush  in  1  discard all held and incoming operations
- out_valid  out  1  ALU operation valid
- out_ready  in  1  ALU/EX accepts the operation
- out_aluop  out  ALUOP_W  operation code to ALU
- out_port_a, out_port_b  out  WORD_SIZE  ALU operands
- out_rd  out  REG_W  destination register, passed along with the operation

Behaviour:
- Handshakes:
  - Input transfer: in_valid & in_ready at the rising edge of CLK.
  - Output transfer: out_valid & out_ready at the rising edge of CLK.
- Storage: main entry M drives the outputs; skid entry S is the overflow slot. Each entry holds aluop, a, b, rd, rs1, rs2 and use_imm.
- States:
  - EMPTY: out_valid=0.
  - ONE: M valid.
  - TWO: M and S valid; in_ready=0.
- Transitions:
  - EMPTY + input -> ONE; the input loads M.
  - ONE + input + output -> ONE; the input loads M.
  - ONE + input, no output -> TWO; the input loads S.
  - ONE + output, no input -> EMPTY.
  - TWO + output -> ONE; S moves to M.
  - All other cases hold the current state.
- in_ready = (next state != TWO), registered. Reset value is 1.
- Latency: an operation accepted at edge N has out_valid=1 after edge N when it lands in M.
- Operand selection at capture, evaluated per operand (rs1 for a, rs2 for b):
  - Take fwd_ex_data if fwd_ex_valid & fwd_ex_rd==rs & rs!=0.
  - Otherwise take fwd_wb_data if fwd_wb_valid & fwd_wb_rd==rs & rs!=0.
  - Otherwise take the register file data.
  - EX has priority over WB.
  - Operand b equals in_imm when in_use_imm=1, and forwarding is ignored for b.
  - Register x0 always reads as the register file value and is never forwarded.
- Refresh while held:
  - Every cycle an entry stays held (it is not transferred out and does not move S->M), its a and b are re-evaluated against the forwarding ports using the same priority and x0 rule.
  - b is not refreshed when use_imm=1.
  - If neither port matches, the operand keeps its value.
  - An S->M move also applies the refresh in the same cycle.
- Flush:
  - Takes priority over every other event.
  - Next state is EMPTY, regardless of any simultaneous input or output transfer.
  - in_ready returns to 1 the cycle after the flush edge.
  - A flushed operation is never presented. The output transfer that happens in the flush cycle itself still counts as a completed transfer.
- Reset (synchronous, RST=1): state EMPTY, out_valid=0, in_ready=1, out_aluop=ALU_ADD encoding, out_port_a=0, out_port_b=0, out_rd=0. Reset mid-operation discards all entries.
- Outputs are driven directly from M. out_* is stable while out_valid & !out_ready, except for operand refresh.
- No arithmetic is performed; operands pass through at WORD_SIZE bits without modification.

Test Plan:
1. Reset, then in: ADD, rs1=1 (data 5), rs2=2 (data 7), rd=3, out_ready=1 -> next cycle out_valid=1, port_a=5, port_b=7, out_rd=3; the cycle after, out_valid=0.
2. Capture with fwd_ex {rd=1, 0x10} and fwd_wb {rd=1, 0x20} both valid, rs1=1 -> port_a=0x10. Repeat with rs1=0 and fwd_ex rd=0 data 0xFF, rf data 0 -> port_a=0.
3. out_ready=0, push 3 operations back-to-back -> first two accepted; in_ready=0 after the second; then out_ready=1 -> outputs appear in order A, B with no loss; in_ready returns to 1.
4. Hold with out_ready=0, rs2=4, use_imm=0, then pulse fwd_wb {rd=4, 0xABCD} -> port_b becomes 0xABCD the next cycle. Same with use_imm=1, imm=0x8 -> port_b stays 0x8.
5. State TWO with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1; neither held operation nor the incoming one is ever presented.
6. Assert RST while in TWO -> next cycle out_valid=0, in_ready=1, port_a=0, port_b=0, out_rd=0.
